fp_mant_mul_seq: RTL and testbench



---
 rtl/fp_mant_mul_seq.sv | 146 ++++++++++++++
 tb/tb_fp_mant_mul_seq.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fp_mant_mul_seq.sv
// Sequential radix-2 shift-and-add mantissa multiplier with start/busy/done handshake.
// Optional feature: define FP_MUL_EARLY_TERM_EN to finish as soon as the remaining multiplier bits are zero.
module fp_mant_mul_seq #(
    parameter int WIDTH = 53
) (
    input  logic                   in_clk,
    input  logic                   in_rst,
    input  logic                   in_start,
    input  logic [WIDTH-1:0]       in_multiplicand,
    input  logic [WIDTH-1:0]       in_multiplier,
    output logic                   out_busy,
    output logic                   out_done,
    output logic [2*WIDTH-1:0]     out_product
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [2*WIDTH:0]     r_p;
    logic [WIDTH-1:0]     r_mcand;
    logic [CW-1:0]        r_cnt;
    logic                 r_busy;
    logic                 r_done;
    logic [2*WIDTH-1:0]   r_product;

    logic [WIDTH:0]       w_upper;
    logic [2*WIDTH:0]     w_p_step;
    logic                 w_last;
    logic                 w_finish;

`ifdef FP_MUL_EARLY_TERM_EN
    logic [WIDTH-1:0]     w_rem_mask;
    logic                 w_rem_zero;
    logic [CW-1:0]        w_shamt;
    logic [2*WIDTH-1:0]   w_cat;
`endif

    // Add-and-shift datapath for one multiplier bit.
    always_comb begin
        w_upper  = r_p[2*WIDTH:WIDTH] + (r_p[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
        w_last   = (r_cnt == CW'(WIDTH-1));
        w_p_step = {1'b0, w_upper, r_p[WIDTH-1:1]};
        w_finish = w_last;
    end

`ifdef FP_MUL_EARLY_TERM_EN
    // Remaining unconsumed multiplier bits sit in P[WIDTH-1-cnt:1]; older low bits are product bits.
    always_comb begin
        w_rem_mask = ({WIDTH{1'b1}} >> r_cnt) & ~{{(WIDTH-1){1'b0}}, 1'b1};
        w_rem_zero = ((r_p[WIDTH-1:0] & w_rem_mask) == {WIDTH{1'b0}});
        w_shamt    = CW'(WIDTH-1) - r_cnt;
        w_cat      = {w_upper, r_p[WIDTH-1:1]};
    end
`endif

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (in_start) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
`ifdef FP_MUL_EARLY_TERM_EN
                if (w_finish || w_rem_zero) begin
`else
                if (w_finish) begin
`endif
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State, operand, accumulator and output registers.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_state   <= ST_IDLE;
            r_p       <= {(2*WIDTH+1){1'b0}};
            r_mcand   <= {WIDTH{1'b0}};
            r_cnt     <= {CW{1'b0}};
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_product <= {(2*WIDTH){1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == ST_RUN);
            r_done  <= (w_state_nxt == ST_DONE);
            case (r_state)
                ST_IDLE: begin
                    if (in_start) begin
                        r_mcand <= in_multiplicand;
                        r_p     <= {{(WIDTH+1){1'b0}}, in_multiplier};
                        r_cnt   <= {CW{1'b0}};
                    end else begin
                        r_mcand <= r_mcand;
                    end
                end
                ST_RUN: begin
                    r_cnt <= r_cnt + CW'(1);
`ifdef FP_MUL_EARLY_TERM_EN
                    if (w_rem_zero && !w_last) begin
                        r_p       <= {1'b0, w_cat >> w_shamt};
                        r_product <= w_cat >> w_shamt;
                    end else if (w_last) begin
                        r_p       <= w_p_step;
                        r_product <= w_p_step[2*WIDTH-1:0];
                    end else begin
                        r_p       <= w_p_step;
                    end
`else
                    r_p <= w_p_step;
                    if (w_finish) begin
                        r_product <= w_p_step[2*WIDTH-1:0];
                    end else begin
                        r_product <= r_product;
                    end
`endif
                end
                default: begin
                    r_p <= r_p;
                end
            endcase
        end
    end

    assign out_busy    = r_busy;
    assign out_done    = r_done;
    assign out_product = r_product;

endmodule

// File: tb/tb_fp_mant_mul_seq.sv
// Self-checking bench for fp_mant_mul_seq: directed cases plus random operands
// compared against a plain-arithmetic product and latency model.
module tb_fp_mant_mul_seq;

    localparam int W = 53;

    logic             in_clk = 1'b0;
    logic             in_rst = 1'b1;
    logic             in_start = 1'b0;
    logic [W-1:0]     in_multiplicand = '0;
    logic [W-1:0]     in_multiplier = '0;
    logic             out_busy;
    logic             out_done;
    logic [2*W-1:0]   out_product;

    int checks = 0;
    int errors = 0;

    fp_mant_mul_seq #(.WIDTH(W)) dut (
        .in_clk          (in_clk),
        .in_rst          (in_rst),
        .in_start        (in_start),
        .in_multiplicand (in_multiplicand),
        .in_multiplier   (in_multiplier),
        .out_busy        (out_busy),
        .out_done        (out_done),
        .out_product     (out_product)
    );

    always #5 in_clk = ~in_clk;

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] wa;
        logic [2*W-1:0] wb;
        wa = {{W{1'b0}}, a};
        wb = {{W{1'b0}}, b};
        return wa * wb;
    endfunction

    function automatic int ref_lat(input logic [W-1:0] b);
`ifdef FP_MUL_EARLY_TERM_EN
        int m;
        m = 0;
        for (int i = 0; i < W; i++) begin
            if (b[i]) m = i + 1;
        end
        return (m < 1) ? 1 : m;
`else
        return W + 0 * int'(b[0]);
`endif
    endfunction

    function automatic logic [W-1:0] rand_op();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[W-1:0];
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge in_clk);
        in_start = 1'b1;
        in_multiplicand = a;
        in_multiplier = b;
        @(posedge in_clk);
        #1;
        in_start = 1'b0;
    endtask

    // Called #1 after the accepting edge; returns #1 after the edge raising out_done.
    task automatic wait_result(input logic [2*W-1:0] exp_p, input int exp_l,
                               input int pa, input int pb, input string tag);
        int lat;
        int busy_cnt;
        lat = 0;
        busy_cnt = 0;
        while (out_done !== 1'b1 && lat < 400) begin
            if (out_busy === 1'b1) busy_cnt++;
            in_start = (lat == pa || lat == pb);
            in_multiplicand = rand_op();
            in_multiplier = rand_op();
            @(posedge in_clk);
            #1;
            lat++;
        end
        in_start = 1'b0;
        check({tag, " latency"}, 128'(lat), 128'(exp_l));
        check({tag, " busy_cycles"}, 128'(busy_cnt), 128'(exp_l));
        check({tag, " product"}, 128'(out_product), 128'(exp_p));
        check({tag, " busy_at_done"}, 128'(out_busy), 128'(0));
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        logic [2*W-1:0] e;
        e = ref_mul(a, b);
        launch(a, b);
        wait_result(e, ref_lat(b), -1, -1, tag);
        @(posedge in_clk);
        #1;
        check({tag, " done_pulse"}, 128'(out_done), 128'(0));
        check({tag, " held"}, 128'(out_product), 128'(e));
    endtask

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] a2;
        logic [W-1:0] b2;
        int done_seen;

        // Reset with start asserted: must not be honoured.
        in_start = 1'b1;
        in_multiplicand = rand_op();
        in_multiplier = rand_op();
        repeat (3) @(posedge in_clk);
        #1;
        check("reset busy", 128'(out_busy), 128'(0));
        check("reset done", 128'(out_done), 128'(0));
        check("reset product", 128'(out_product), 128'(0));
        in_rst = 1'b0;
        in_start = 1'b0;
        @(posedge in_clk);
        #1;
        check("idle after reset", 128'(out_busy), 128'(0));

        // Directed cases.
        run_op(53'h10000000000000, 53'h10000000000000, "one_x_one");
        check("one_x_one bit104", 128'(out_product), 128'(106'h1) << 104);
        run_op(53'h1FFFFFFFFFFFFF, 53'h1FFFFFFFFFFFFF, "max_x_max");
        check("max_x_max const", 128'(out_product), 128'(106'h3FFFFFFFFFFFFC0000000000001));
        run_op(53'h18000000000000, 53'h1FFFFFFFFFFFFF, "one5_x_max");
        run_op(53'h0, 53'h1FFFFFFFFFFFF, "zero_a");
        check("zero_a const", 128'(out_product), 128'(0));
        run_op(53'h10000000000000, 53'h1, "b_one");
        run_op(rand_op(), 53'h10000000000000, "b_top");
        run_op(rand_op(), 53'h0, "b_zero");
        run_op(rand_op(), 53'h5, "b_small");

        // Start pulses mid-run are ignored; start held through DONE is taken only from IDLE.
        a = rand_op() | 53'h10000000000000;
        b = rand_op() | 53'h10000000000000;
        launch(a, b);
        wait_result(ref_mul(a, b), ref_lat(b), 5, 20, "ignore_start");
        a2 = rand_op();
        b2 = rand_op() | 53'h10000000000000;
        in_start = 1'b1;
        in_multiplicand = a2;
        in_multiplier = b2;
        @(posedge in_clk);
        #1;
        check("done_state busy", 128'(out_busy), 128'(0));
        check("done_state pulse", 128'(out_done), 128'(0));
        check("done_state held", 128'(out_product), 128'(ref_mul(a, b)));
        @(posedge in_clk);
        #1;
        check("accept from idle", 128'(out_busy), 128'(1));
        in_start = 1'b0;
        wait_result(ref_mul(a2, b2), ref_lat(b2), -1, -1, "back_to_back");

        // Reset in the middle of a run.
        a = rand_op();
        b = rand_op() | 53'h10000000000000;
        launch(a, b);
        repeat (29) @(posedge in_clk);
        #1;
        in_rst = 1'b1;
        in_start = 1'b1;
        @(posedge in_clk);
        #1;
        check("midrst busy", 128'(out_busy), 128'(0));
        check("midrst done", 128'(out_done), 128'(0));
        check("midrst product", 128'(out_product), 128'(0));
        in_rst = 1'b0;
        in_start = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge in_clk);
            #1;
            if (out_done === 1'b1 || out_busy === 1'b1) done_seen++;
        end
        check("midrst no activity", 128'(done_seen), 128'(0));
        run_op(a, b, "after_rst");

        // Random operands, mixed with normalised ones.
        for (int k = 0; k < 8; k++) begin
            a = rand_op();
            b = rand_op();
            if (k[0]) begin
                a[W-1] = 1'b1;
                b[W-1] = 1'b1;
            end
            if (k == 6) b = b >> 40;
            run_op(a, b, $sformatf("rand%0d", k));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
